// File: rtl/mod_n_down_counter.sv
// mod_n_down_counter: synchronous mod-N down counter (N-1 .. 0, then back to N-1).
// Parallel load (clamped to N-1), count enable, combinational terminal count and
// a registered one-cycle wrap pulse.
// Build option: define MODN_DOWN_ONESHOT_EN for one-shot mode. In that mode the
// counter parks at 0 and raises a sticky done flag instead of wrapping. The port
// list is the same in both builds.
module mod_n_down_counter #(
    parameter int unsigned N     = 3,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(N - 1);

    // Reject a modulus below 2 or a count width too narrow to hold N-1.
    if (N < 2 || (64'd1 << WIDTH) < 64'(N)) begin : g_bad_params
        $error("mod_n_down_counter: illegal parameters N=%0d WIDTH=%0d", N, WIDTH);
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_zero;

    // Out-of-range load values saturate to the top count so Q stays legal.
    assign load_clamped = (load_val_i > MaxVal) ? MaxVal : load_val_i;
    assign at_zero      = (q_q == '0);

`ifdef MODN_DOWN_ONESHOT_EN
    logic done_q, done_d;

    // Next state, one-shot: load > enable > hold; parks at 0 and sets done.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        done_d = done_q;
        if (load_i) begin
            q_d    = load_clamped;
            done_d = 1'b0;
        end else if (en_i) begin
            if (at_zero) begin
                done_d = 1'b1;
            end else begin
                q_d = q_q - WIDTH'(1);
            end
        end
    end

    // Sticky expiry flag, cleared only by load or reset.
    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
`else
    // Next state, free-running: load > enable > hold; 0 wraps to N-1.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (load_i) begin
            q_d = load_clamped;
        end else if (en_i) begin
            if (at_zero) begin
                q_d    = MaxVal;
                wrap_d = 1'b1;
            end else begin
                q_d = q_q - WIDTH'(1);
            end
        end
    end

    assign done_o = 1'b0;
`endif

    // Count and wrap-pulse registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q_o    = q_q;
    assign tc_o   = at_zero;
    assign wrap_o = wrap_q;

    // The count must never leave 0..N-1.
    a_q_in_range : assert property (@(posedge clk_i) disable iff (!clr_ni) q_q <= MaxVal);

endmodule
